// File: rtl/cp0_exc_pkg.sv
// rtl/cp0_exc_pkg.sv - CP0 addresses, exception codes, field positions and exception arbiter
package cp0_defs;

    localparam logic [7:0] CP0_BADVADDR = {5'd8,  3'd0};
    localparam logic [7:0] CP0_COUNT    = {5'd9,  3'd0};
    localparam logic [7:0] CP0_COMPARE  = {5'd11, 3'd0};
    localparam logic [7:0] CP0_STATUS   = {5'd12, 3'd0};
    localparam logic [7:0] CP0_CAUSE    = {5'd13, 3'd0};
    localparam logic [7:0] CP0_EPC      = {5'd14, 3'd0};

    typedef enum logic [4:0] {
        EXC_INT  = 5'h00,
        EXC_ADEL = 5'h04,
        EXC_ADES = 5'h05,
        EXC_SYS  = 5'h08,
        EXC_BP   = 5'h09,
        EXC_RI   = 5'h0A,
        EXC_OV   = 5'h0C
    } exc_code_e;

    localparam int ST_IE     = 0;
    localparam int ST_EXL    = 1;
    localparam int ST_IM_LO  = 8;
    localparam int ST_IM_HI  = 15;
    localparam int ST_BEV    = 22;
    localparam logic [31:0] STATUS_RESET = 32'h0040_0000;

    localparam int CA_EXC_LO = 2;
    localparam int CA_EXC_HI = 6;
    localparam int CA_IP_LO  = 8;
    localparam int CA_IP_HI  = 15;
    localparam int CA_TI     = 30;
    localparam int CA_BD     = 31;

    localparam int EXB_LS      = 0;
    localparam int EXB_BP      = 1;
    localparam int EXB_SYS     = 2;
    localparam int EXB_OV      = 3;
    localparam int EXB_RI      = 4;
    localparam int EXB_ADEL_IF = 5;

    typedef enum logic [1:0] {
        BADV_KEEP = 2'd0,
        BADV_PC   = 2'd1,
        BADV_LS   = 2'd2
    } badv_src_e;

    typedef struct packed {
        logic      take;
        exc_code_e code;
        badv_src_e badv_src;
    } exc_sel_t;

    // Priority: Int, AdEL-fetch, RI, Ov, Sys, Bp, AdEL/AdES load-store
    function automatic exc_sel_t exc_select(input logic int_req, input logic [5:0] exc,
                                            input logic ls_store);
        exc_sel_t s;
        s.take     = int_req | (|exc);
        s.code     = EXC_INT;
        s.badv_src = BADV_KEEP;
        if (int_req) begin
            s.code = EXC_INT;
        end else if (exc[EXB_ADEL_IF]) begin
            s.code     = EXC_ADEL;
            s.badv_src = BADV_PC;
        end else if (exc[EXB_RI]) begin
            s.code = EXC_RI;
        end else if (exc[EXB_OV]) begin
            s.code = EXC_OV;
        end else if (exc[EXB_SYS]) begin
            s.code = EXC_SYS;
        end else if (exc[EXB_BP]) begin
            s.code = EXC_BP;
        end else if (exc[EXB_LS]) begin
            s.code     = ls_store ? EXC_ADES : EXC_ADEL;
            s.badv_src = BADV_LS;
        end
        return s;
    endfunction

endpackage

// File: rtl/cp0_exc_if.sv
// rtl/cp0_exc_if.sv - MEM-stage to CP0 bus with pipeline and CP0 views
interface cp0_exc_if;
    logic        mem_valid;
    logic [31:0] mem_pc;
    logic        mem_bd;
    logic [5:0]  mem_exc;
    logic        mem_ls_store;
    logic [31:0] mem_ls_vaddr;
    logic        mem_eret;
    logic        mem_cp0wen;
    logic [7:0]  mem_cp0addr;
    logic [31:0] mem_cp0wdata;
    logic        exc_oc;
    logic        eret;
    logic [31:0] redirect_pc;
    logic [31:0] cp0_rdata;
    logic        status_exl;

    modport master (
        output mem_valid, mem_pc, mem_bd, mem_exc, mem_ls_store, mem_ls_vaddr,
               mem_eret, mem_cp0wen, mem_cp0addr, mem_cp0wdata,
        input  exc_oc, eret, redirect_pc, cp0_rdata, status_exl
    );

    modport slave (
        input  mem_valid, mem_pc, mem_bd, mem_exc, mem_ls_store, mem_ls_vaddr,
               mem_eret, mem_cp0wen, mem_cp0addr, mem_cp0wdata,
        output exc_oc, eret, redirect_pc, cp0_rdata, status_exl
    );
endinterface

// File: rtl/cp0_exc_timer.sv
// rtl/cp0_exc_timer.sv - Count/Compare timer with free-running prescaler and sticky TI
module cp0_timer #(
    parameter int unsigned COUNT_DIV = 2
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        i_count_wen,
    input  logic        i_compare_wen,
    input  logic [31:0] i_wdata,
    input  logic        i_ti_clr,
    output logic [31:0] o_count,
    output logic [31:0] o_compare,
    output logic        o_ti
);
    localparam int DIV_W = (COUNT_DIV > 1) ? $clog2(COUNT_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(COUNT_DIV - 1);

    logic [DIV_W-1:0] r_div;
    logic [31:0]      r_count;
    logic [31:0]      r_compare;
    logic             r_ti;
    logic             w_tick;
    logic             w_match;

    assign w_tick  = (r_div == DIV_LAST);
    assign w_match = (r_count == r_compare) && (r_compare != 32'd0);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_div     <= '0;
            r_count   <= '0;
            r_compare <= '0;
            r_ti      <= 1'b0;
        end else begin
            // A software Count write restarts the prescaler so the next tick is a full period away
            if (i_count_wen) begin
                r_count <= i_wdata;
                r_div   <= '0;
            end else begin
                r_div <= w_tick ? '0 : r_div + 1'b1;
                if (w_tick) begin
                    r_count <= r_count + 32'd1;
                end
            end
            if (i_compare_wen) begin
                r_compare <= i_wdata;
            end
            if (i_ti_clr) begin
                r_ti <= 1'b0;
            end else if (w_match) begin
                r_ti <= 1'b1;
            end
        end
    end

    assign o_count   = r_count;
    assign o_compare = r_compare;
    assign o_ti      = r_ti;
endmodule

// File: rtl/cp0_exc.sv
// rtl/cp0_exc.sv - CP0 register file and precise-exception arbiter at the MEM stage
module cp0_exc
    import cp0_defs::*;
#(
    parameter logic [31:0] EXC_ENTRY = 32'hBFC0_0380,
    parameter int unsigned COUNT_DIV = 2
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic [5:0] hw_int,
    cp0_exc_if.slave   bus
);
    logic [7:0]  r_status_im;
    logic        r_status_exl;
    logic        r_status_ie;
    logic        r_cause_bd;
    logic [5:0]  r_cause_ip_hw;
    logic [1:0]  r_cause_ip_sw;
    exc_code_e   r_cause_exc;
    logic [31:0] r_epc;
    logic [31:0] r_badvaddr;

    logic [31:0] w_count;
    logic [31:0] w_compare;
    logic        w_ti;
    logic [31:0] w_status;
    logic [31:0] w_cause;
    logic        w_int_req;
    exc_sel_t    w_sel;
    logic        w_exc_oc;
    logic        w_eret;
    logic        w_wen;
    logic        w_wen_status;
    logic        w_wen_cause;
    logic        w_wen_epc;
    logic        w_wen_count;
    logic        w_wen_compare;
    logic [31:0] w_rdata;
    logic [31:0] w_redirect;

    always_comb begin
        w_status                     = STATUS_RESET;
        w_status[ST_IM_HI:ST_IM_LO]  = r_status_im;
        w_status[ST_EXL]             = r_status_exl;
        w_status[ST_IE]              = r_status_ie;

        w_cause                        = '0;
        w_cause[CA_BD]                 = r_cause_bd;
        w_cause[CA_TI]                 = w_ti;
        w_cause[CA_IP_HI:CA_IP_LO]     = {r_cause_ip_hw, r_cause_ip_sw};
        w_cause[CA_EXC_HI:CA_EXC_LO]   = r_cause_exc;
    end

    assign w_int_req = r_status_ie & ~r_status_exl
                     & (|({r_cause_ip_hw, r_cause_ip_sw} & r_status_im));
    assign w_sel     = exc_select(w_int_req, bus.mem_exc, bus.mem_ls_store);
    assign w_exc_oc  = bus.mem_valid & w_sel.take;
    assign w_eret    = bus.mem_valid & bus.mem_eret & ~w_exc_oc;

    // The faulting instruction's own MTC0 never commits
    assign w_wen         = bus.mem_valid & bus.mem_cp0wen & ~w_exc_oc;
    assign w_wen_status  = w_wen & (bus.mem_cp0addr == CP0_STATUS);
    assign w_wen_cause   = w_wen & (bus.mem_cp0addr == CP0_CAUSE);
    assign w_wen_epc     = w_wen & (bus.mem_cp0addr == CP0_EPC);
    assign w_wen_count   = w_wen & (bus.mem_cp0addr == CP0_COUNT);
    assign w_wen_compare = w_wen & (bus.mem_cp0addr == CP0_COMPARE);

    cp0_timer #(
        .COUNT_DIV (COUNT_DIV)
    ) u_timer (
        .clk           (clk),
        .resetn        (resetn),
        .i_count_wen   (w_wen_count),
        .i_compare_wen (w_wen_compare),
        .i_wdata       (bus.mem_cp0wdata),
        .i_ti_clr      (w_wen_compare),
        .o_count       (w_count),
        .o_compare     (w_compare),
        .o_ti          (w_ti)
    );

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_status_im   <= '0;
            r_status_exl  <= 1'b0;
            r_status_ie   <= 1'b0;
            r_cause_bd    <= 1'b0;
            r_cause_ip_hw <= '0;
            r_cause_ip_sw <= '0;
            r_cause_exc   <= EXC_INT;
            r_epc         <= '0;
            r_badvaddr    <= '0;
        end else begin
            r_cause_ip_hw <= {hw_int[5] | w_ti, hw_int[4:0]};
            if (w_exc_oc) begin
                r_cause_exc  <= w_sel.code;
                r_status_exl <= 1'b1;
                // A nested exception keeps the EPC/BD of the outermost one
                if (!r_status_exl) begin
                    r_epc      <= bus.mem_bd ? bus.mem_pc - 32'd4 : bus.mem_pc;
                    r_cause_bd <= bus.mem_bd;
                end
                case (w_sel.badv_src)
                    BADV_PC: r_badvaddr <= bus.mem_pc;
                    BADV_LS: r_badvaddr <= bus.mem_ls_vaddr;
                    default: ;
                endcase
            end else begin
                if (w_wen_status) begin
                    r_status_im  <= bus.mem_cp0wdata[ST_IM_HI:ST_IM_LO];
                    r_status_exl <= bus.mem_cp0wdata[ST_EXL];
                    r_status_ie  <= bus.mem_cp0wdata[ST_IE];
                end
                if (w_eret) begin
                    r_status_exl <= 1'b0;
                end
                if (w_wen_cause) begin
                    r_cause_ip_sw <= bus.mem_cp0wdata[CA_IP_LO+1:CA_IP_LO];
                end
                if (w_wen_epc) begin
                    r_epc <= bus.mem_cp0wdata;
                end
            end
        end
    end

    always_comb begin
        w_rdata = '0;
        case (bus.mem_cp0addr)
            CP0_BADVADDR: w_rdata = r_badvaddr;
            CP0_COUNT:    w_rdata = w_count;
            CP0_COMPARE:  w_rdata = w_compare;
            CP0_STATUS:   w_rdata = w_status;
            CP0_CAUSE:    w_rdata = w_cause;
            CP0_EPC:      w_rdata = r_epc;
            default:      w_rdata = '0;
        endcase
    end

    always_comb begin
        w_redirect = '0;
        if (w_exc_oc) begin
            w_redirect = EXC_ENTRY;
        end else if (w_eret) begin
            w_redirect = r_epc;
        end
    end

    assign bus.exc_oc      = w_exc_oc;
    assign bus.eret        = w_eret;
    assign bus.redirect_pc = w_redirect;
    assign bus.cp0_rdata   = w_rdata;
    assign bus.status_exl  = r_status_exl;
endmodule

// File: tb/tb_cp0_exc.sv
// tb/tb_cp0_exc.sv - self-checking bench for cp0_exc
module tb_cp0_exc;
    localparam logic [7:0] A_BADV = 8'h40;
    localparam logic [7:0] A_CNT  = 8'h48;
    localparam logic [7:0] A_CMP  = 8'h58;
    localparam logic [7:0] A_ST   = 8'h60;
    localparam logic [7:0] A_CA   = 8'h68;
    localparam logic [7:0] A_EPC  = 8'h70;
    localparam logic [31:0] ENTRY = 32'hBFC0_0380;
    localparam int S_OC = 0, S_ER = 1, S_RD = 2, S_DATA = 3, S_EXL = 4;

    logic       clk;
    logic       resetn;
    logic [5:0] hw_int;
    int         checks;
    int         failures;

    cp0_exc_if bus ();

    cp0_exc dut (
        .clk    (clk),
        .resetn (resetn),
        .hw_int (hw_int),
        .bus    (bus)
    );

    typedef struct {
        string       name;
        int          sel;
        logic [31:0] exp;
    } sb_t;
    sb_t sb_q[$];

    typedef struct {
        logic [31:0] pc;
        logic        bd;
        logic [5:0]  exc;
        logic        st;
        logic [31:0] va;
        logic        wen;
        logic        oc;
        logic [4:0]  code;
        logic [31:0] epc;
        logic        cbd;
        logic [31:0] badv;
    } vec_t;
    vec_t vecs[8];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout required finish");
        $fatal(1);
    end

    function automatic logic [31:0] get_out(input int sel);
        case (sel)
            S_OC:    return {31'b0, bus.exc_oc};
            S_ER:    return {31'b0, bus.eret};
            S_RD:    return bus.redirect_pc;
            S_DATA:  return bus.cp0_rdata;
            default: return {31'b0, bus.status_exl};
        endcase
    endfunction

    function automatic logic [31:0] mk_cause(input logic bd, input logic [4:0] code);
        logic [31:0] c;
        c     = 32'(code) << 2;
        c[31] = bd;
        return c;
    endfunction

    task automatic expect_out(input string name, input int sel, input logic [31:0] exp);
        sb_t e;
        e.name = name;
        e.sel  = sel;
        e.exp  = exp;
        sb_q.push_back(e);
    endtask

    task automatic check_now();
        sb_t         e;
        logic [31:0] act;
        #1;
        while (sb_q.size() > 0) begin
            e   = sb_q.pop_front();
            act = get_out(e.sel);
            checks++;
            if (act !== e.exp) begin
                failures++;
                $display("FAIL %s: got %h required %h", e.name, act, e.exp);
            end
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic clear_bus();
        bus.mem_valid    = 1'b0;
        bus.mem_pc       = '0;
        bus.mem_bd       = 1'b0;
        bus.mem_exc      = '0;
        bus.mem_ls_store = 1'b0;
        bus.mem_ls_vaddr = '0;
        bus.mem_eret     = 1'b0;
        bus.mem_cp0wen   = 1'b0;
        bus.mem_cp0addr  = '0;
        bus.mem_cp0wdata = '0;
    endtask

    task automatic drive(input logic [31:0] pc, input logic bd, input logic [5:0] exc,
                         input logic st, input logic [31:0] va, input logic er,
                         input logic wen, input logic [7:0] addr, input logic [31:0] wd);
        bus.mem_valid    = 1'b1;
        bus.mem_pc       = pc;
        bus.mem_bd       = bd;
        bus.mem_exc      = exc;
        bus.mem_ls_store = st;
        bus.mem_ls_vaddr = va;
        bus.mem_eret     = er;
        bus.mem_cp0wen   = wen;
        bus.mem_cp0addr  = addr;
        bus.mem_cp0wdata = wd;
    endtask

    task automatic mtc0(input logic [7:0] addr, input logic [31:0] wd);
        drive(32'h8000_0F00, 1'b0, 6'd0, 1'b0, 32'd0, 1'b0, 1'b1, addr, wd);
        step(1);
        clear_bus();
    endtask

    task automatic rd_check(input string name, input logic [7:0] addr, input logic [31:0] exp);
        bus.mem_cp0addr = addr;
        expect_out(name, S_DATA, exp);
        check_now();
    endtask

    task automatic expect_flow(input string name, input logic oc, input logic er,
                               input logic [31:0] rd);
        expect_out({name, "_exc_oc"}, S_OC, {31'b0, oc});
        expect_out({name, "_eret"}, S_ER, {31'b0, er});
        expect_out({name, "_redirect"}, S_RD, rd);
        check_now();
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        resetn   = 1'b0;
        hw_int   = '0;
        clear_bus();

        vecs[0] = '{32'h8000_1004, 1'b1, 6'b000100, 1'b0, 32'h0, 1'b0,
                    1'b1, 5'h08, 32'h8000_1000, 1'b1, 32'h0};
        vecs[1] = '{32'h8000_3000, 1'b0, 6'b000010, 1'b0, 32'h0, 1'b0,
                    1'b1, 5'h09, 32'h8000_3000, 1'b0, 32'h0};
        vecs[2] = '{32'h8000_4001, 1'b0, 6'b110000, 1'b0, 32'h0, 1'b0,
                    1'b1, 5'h04, 32'h8000_4001, 1'b0, 32'h8000_4001};
        vecs[3] = '{32'h8000_5000, 1'b0, 6'b001110, 1'b0, 32'h0, 1'b0,
                    1'b1, 5'h0C, 32'h8000_5000, 1'b0, 32'h8000_4001};
        vecs[4] = '{32'h8000_6000, 1'b0, 6'b000001, 1'b0, 32'h1234_5679, 1'b0,
                    1'b1, 5'h04, 32'h8000_6000, 1'b0, 32'h1234_5679};
        vecs[5] = '{32'h8000_7000, 1'b0, 6'b000001, 1'b1, 32'h8000_0003, 1'b1,
                    1'b1, 5'h05, 32'h8000_7000, 1'b0, 32'h8000_0003};
        vecs[6] = '{32'h8000_7100, 1'b0, 6'b000000, 1'b0, 32'h0, 1'b1,
                    1'b0, 5'h05, 32'hDEAD_BEEF, 1'b0, 32'h8000_0003};
        vecs[7] = '{32'h8000_8000, 1'b1, 6'b010001, 1'b1, 32'h1111_1111, 1'b0,
                    1'b1, 5'h0A, 32'h8000_7FFC, 1'b1, 32'h8000_0003};

        // Reset: let Count run, then assert reset asynchronously mid-cycle
        step(2);
        resetn = 1'b1;
        step(10);
        rd_check("count_run", A_CNT, 32'd5);
        resetn = 1'b0;
        rd_check("count_async_rst", A_CNT, 32'd0);
        step(2);
        resetn = 1'b1;
        rd_check("rst_count", A_CNT, 32'd0);
        rd_check("rst_status", A_ST, 32'h0040_0000);
        rd_check("rst_cause", A_CA, 32'd0);
        rd_check("rst_epc", A_EPC, 32'd0);
        rd_check("rst_badv", A_BADV, 32'd0);
        rd_check("rst_compare", A_CMP, 32'd0);
        expect_flow("rst", 1'b0, 1'b0, 32'd0);

        // Exception selection and state capture, one vector per loop pass
        for (int i = 0; i < 8; i++) begin
            drive(vecs[i].pc, vecs[i].bd, vecs[i].exc, vecs[i].st, vecs[i].va, 1'b0,
                  vecs[i].wen, A_EPC, 32'hDEAD_BEEF);
            expect_flow($sformatf("v%0d", i), vecs[i].oc, 1'b0, vecs[i].oc ? ENTRY : 32'd0);
            step(1);
            clear_bus();
            rd_check($sformatf("v%0d_cause", i), A_CA, mk_cause(vecs[i].cbd, vecs[i].code));
            rd_check($sformatf("v%0d_epc", i), A_EPC, vecs[i].epc);
            rd_check($sformatf("v%0d_badv", i), A_BADV, vecs[i].badv);
            expect_out($sformatf("v%0d_exl", i), S_EXL, {31'b0, vecs[i].oc});
            check_now();
            if (vecs[i].oc) mtc0(A_ST, 32'd0);
        end

        // Nested exception keeps EPC/BD, then ERET returns to it
        drive(32'h8000_9000, 1'b0, 6'b000100, 1'b0, 32'd0, 1'b0, 1'b0, A_EPC, 32'd0);
        expect_flow("sys", 1'b1, 1'b0, ENTRY);
        step(1);
        clear_bus();
        drive(32'h8000_2000, 1'b1, 6'b011000, 1'b0, 32'd0, 1'b0, 1'b0, A_EPC, 32'd0);
        expect_flow("nested", 1'b1, 1'b0, ENTRY);
        step(1);
        clear_bus();
        rd_check("nested_cause", A_CA, 32'h0000_0028);
        rd_check("nested_epc", A_EPC, 32'h8000_9000);
        drive(32'h8000_2004, 1'b0, 6'd0, 1'b0, 32'd0, 1'b1, 1'b0, A_EPC, 32'd0);
        expect_flow("eret", 1'b0, 1'b1, 32'h8000_9000);
        step(1);
        clear_bus();
        expect_out("eret_exl", S_EXL, 32'd0);
        check_now();

        // Timer interrupt: Count=0, Compare=10, IM7+IE
        mtc0(A_ST, 32'h0000_8001);
        mtc0(A_CNT, 32'd0);
        mtc0(A_CMP, 32'd10);
        step(19);
        rd_check("tmr_count10", A_CNT, 32'd10);
        rd_check("tmr_ti_pre", A_CA, 32'h0000_0028);
        step(1);
        rd_check("tmr_ti_set", A_CA, 32'h4000_0028);
        step(1);
        rd_check("tmr_ip7", A_CA, 32'h4000_8028);
        drive(32'h8000_A000, 1'b0, 6'd0, 1'b0, 32'd0, 1'b0, 1'b0, A_EPC, 32'd0);
        expect_flow("tmr_int", 1'b1, 1'b0, ENTRY);
        step(1);
        clear_bus();
        rd_check("tmr_int_cause", A_CA, 32'h4000_8000);
        rd_check("tmr_int_epc", A_EPC, 32'h8000_A000);
        mtc0(A_CMP, 32'd1000);
        rd_check("tmr_ti_clr", A_CA, 32'h0000_8000);
        step(1);
        rd_check("tmr_ip7_clr", A_CA, 32'h0000_0000);

        // Interrupt masking by IM and EXL
        hw_int = 6'b000001;
        mtc0(A_ST, 32'h0000_0001);
        step(1);
        drive(32'h8000_B000, 1'b0, 6'd0, 1'b0, 32'd0, 1'b0, 1'b0, A_EPC, 32'd0);
        expect_flow("mask_im", 1'b0, 1'b0, 32'd0);
        step(1);
        clear_bus();
        mtc0(A_ST, 32'h0000_0401);
        drive(32'h8000_C000, 1'b0, 6'd0, 1'b0, 32'd0, 1'b0, 1'b0, A_EPC, 32'd0);
        expect_flow("unmask", 1'b1, 1'b0, ENTRY);
        step(1);
        clear_bus();
        rd_check("unmask_cause", A_CA, 32'h0000_0400);
        rd_check("unmask_epc", A_EPC, 32'h8000_C000);
        drive(32'h8000_D000, 1'b0, 6'd0, 1'b0, 32'd0, 1'b0, 1'b0, A_EPC, 32'd0);
        expect_flow("mask_exl", 1'b0, 1'b0, 32'd0);
        step(1);
        clear_bus();
        hw_int = '0;

        // Same-cycle MTC0 read returns the old value
        drive(32'h8000_E000, 1'b0, 6'd0, 1'b0, 32'd0, 1'b0, 1'b1, A_EPC, 32'h1234_5678);
        expect_out("rd_old", S_DATA, 32'h8000_C000);
        check_now();
        step(1);
        clear_bus();
        rd_check("rd_new", A_EPC, 32'h1234_5678);

        // BadVAddr is read-only, unimplemented addresses read 0, Count wraps
        mtc0(A_BADV, 32'd0);
        rd_check("badv_ro", A_BADV, 32'h8000_0003);
        rd_check("unimpl_rd", 8'h08, 32'd0);
        mtc0(A_CNT, 32'hFFFF_FFFF);
        rd_check("cnt_max", A_CNT, 32'hFFFF_FFFF);
        step(2);
        rd_check("cnt_wrap", A_CNT, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
